// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared definitions for the instruction memory boot loader:
//               FSM state encoding, stream field sizes and the address
//               stride that is also used by the PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_LEN  = 2'd1;
    localparam state_t S_DATA = 2'd2;
    localparam state_t S_FIN  = 2'd3;

    // Bytes in the little-endian word-count header and in one instruction
    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Byte distance between consecutive instructions (same as PC + 4)
    localparam logic [63:0] ADDR_STRIDE = 64'h4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_byte_assembler
// Description : Collects NBYTES stream bytes into a little-endian word. The
//               first byte lands in bits 7:0. o_word is valid together with
//               o_word_valid, in the same cycle as the final byte.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_byte_assembler #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic [8*NBYTES-1:0]   o_word,
    output logic                  o_word_valid
);

    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NBYTES - 1);

    // Only the earlier bytes need storage; the final byte is used directly
    // from the input so the word is available without an extra cycle.
    logic [8*(NBYTES-1)-1:0] r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic [8*NBYTES-1:0]     w_next;

    assign w_next       = {i_data, r_shift};
    assign o_word       = w_next;
    assign o_word_valid = i_valid && (r_cnt == c_LAST);

    // Shift accepted bytes in from the top; restart counting after a full word
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= w_next[8*NBYTES-1:8];
            r_cnt   <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : imem_loader_byte_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time writer for the instruction memory. Receives a byte
//               stream (16-bit LE word count, then LE 32-bit words), issues
//               one-cycle write strobes and holds the core in reset until the
//               image is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                MEM_WORDS = 256,
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    state_t              r_state;
    state_t              w_next_state;

    logic                w_accept;
    logic                w_start_ok;
    logic                w_len_valid;
    logic                w_word_valid;
    logic                w_in_range;
    logic                w_last_word;
    logic [15:0]         w_len_word;
    logic [31:0]         w_data_word;
    logic [ADDR_W-1:0]   w_wr_addr;

    logic [15:0]         r_len;
    logic [15:0]         r_idx;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [15:0]         r_words;

    assign w_accept    = rx_valid && rx_ready;
    assign w_start_ok  = start && (r_state == S_IDLE);
    assign w_in_range  = ({16'd0, r_idx} < 32'(MEM_WORDS));
    assign w_last_word = (r_idx == r_len - 16'd1);
    assign w_wr_addr   = BASE_ADDR + ADDR_W'(r_idx) * ADDR_W'(ADDR_STRIDE);

    imem_loader_byte_assembler #(
        .NBYTES (LEN_BYTES)
    ) u_len_asm (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_start_ok),
        .i_valid      (w_accept && (r_state == S_LEN)),
        .i_data       (rx_data),
        .o_word       (w_len_word),
        .o_word_valid (w_len_valid)
    );

    imem_loader_byte_assembler #(
        .NBYTES (WORD_BYTES)
    ) u_word_asm (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_start_ok),
        .i_valid      (w_accept && (r_state == S_DATA)),
        .i_data       (rx_data),
        .o_word       (w_data_word),
        .o_word_valid (w_word_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start)        w_next_state = S_LEN;
            S_LEN:  if (w_len_valid)  w_next_state = (w_len_word == 16'd0) ? S_FIN : S_DATA;
            S_DATA: if (w_word_valid && w_last_word) w_next_state = S_FIN;
            S_FIN:                    w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // Handshake output: bytes are taken while reading the header or payload
    always_comb begin
        rx_ready = (r_state == S_LEN) || (r_state == S_DATA);
    end

    // Datapath: length capture, write registration, status flags.
    // The final write is issued during the first FIN cycle, so FIN can
    // release the core on that same cycle edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
        end else begin
            r_we <= 1'b0;
            if (r_we) begin
                r_words <= r_words + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_words     <= '0;
                        r_busy      <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_idx       <= '0;
                        r_len       <= '0;
                    end
                end
                S_LEN: begin
                    if (w_len_valid) begin
                        r_len <= w_len_word;
                    end
                end
                S_DATA: begin
                    if (w_word_valid) begin
                        r_idx <= r_idx + 16'd1;
                        if (w_in_range) begin
                            r_we    <= 1'b1;
                            r_addr  <= w_wr_addr;
                            r_wdata <= w_data_word;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_cpu_reset <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader. Stimulus pushes expected
//               writes and status checks into queues; a negedge monitor pops
//               and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 64;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    chk_t       chk_q[$];
    wr_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] img[10];

    imem_loader #(
        .MEM_WORDS (2),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (64'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Monitor: drain queued status checks and match every write strobe
    always @(negedge clk) begin
        chk_t c;
        wr_t  w;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h, expected %0h", c.name, c.act, c.exp);
            end
        end
        if (imem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                w = exp_q.pop_front();
                if (imem_addr !== w.addr || imem_wdata !== w.data) begin
                    n_bad++;
                    $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                             imem_addr, imem_wdata, w.addr, w.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_q.push_back('{name, act, exp});
    endtask

    task automatic exp_wr(input logic [63:0] addr, input logic [31:0] data);
        exp_q.push_back('{addr, data});
    endtask

    // Present one byte and hold it until accepted; called at a negedge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_prog(input bit gap);
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rx_ready"},  64'(rx_ready),     64'd0);
        chk({tag, "_imem_we"},   64'(imem_we),      64'd0);
        chk({tag, "_addr"},      64'(imem_addr),    64'd0);
        chk({tag, "_wdata"},     64'(imem_wdata),   64'd0);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset),    64'd1);
        chk({tag, "_busy"},      64'(busy),         64'd0);
        chk({tag, "_done"},      64'(done),         64'd0);
        chk({tag, "_err"},       64'(err),          64'd0);
        chk({tag, "_words"},     64'(words_loaded), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back image with exact release timing
        exp_wr(64'h0, 32'h00100513);
        exp_wr(64'h4, 32'h00200593);
        pulse_start();
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_cpu_reset_start", 64'(cpu_reset), 64'd1);
        send_prog(1'b0);
        chk("a_we_last", 64'(imem_we), 64'd1);
        chk("a_cpu_reset_during_write", 64'(cpu_reset), 64'd1);
        @(negedge clk);
        chk("a_cpu_reset_after", 64'(cpu_reset), 64'd0);
        chk("a_done", 64'(done), 64'd1);
        chk("a_busy_end", 64'(busy), 64'd0);
        chk("a_words", 64'(words_loaded), 64'd2);
        chk("a_err", 64'(err), 64'd0);

        // Reload after done with gaps between bytes
        exp_wr(64'h0, 32'h00100513);
        exp_wr(64'h4, 32'h00200593);
        pulse_start();
        chk("b_done_cleared", 64'(done), 64'd0);
        chk("b_cpu_reset_reload", 64'(cpu_reset), 64'd1);
        chk("b_words_cleared", 64'(words_loaded), 64'd0);
        send_prog(1'b1);
        wait_done();
        chk("b_words", 64'(words_loaded), 64'd2);
        chk("b_cpu_reset", 64'(cpu_reset), 64'd0);

        // Empty image
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        chk("c_done", 64'(done), 64'd1);
        chk("c_err", 64'(err), 64'd0);
        chk("c_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("c_words", 64'(words_loaded), 64'd0);

        // Overflow: three words into a two-word memory
        exp_wr(64'h0, 32'h00100513);
        exp_wr(64'h4, 32'h00200593);
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 2; i < 10; i++) send_byte(img[i]);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        wait_done();
        chk("d_err", 64'(err), 64'd1);
        chk("d_words", 64'(words_loaded), 64'd2);
        chk("d_done", 64'(done), 64'd1);

        // Reset mid-load after six data bytes, start coincident with reset
        exp_wr(64'h0, 32'h00100513);
        pulse_start();
        chk("e_err_cleared", 64'(err), 64'd0);
        for (int i = 0; i < 8; i++) send_byte(img[i]);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk_reset_values("e");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("e_start_ignored", 64'(busy), 64'd0);
        exp_wr(64'h0, 32'h00100513);
        exp_wr(64'h4, 32'h00200593);
        pulse_start();
        send_prog(1'b0);
        wait_done();
        chk("e_words", 64'(words_loaded), 64'd2);

        // start pulsed during DATA is ignored
        exp_wr(64'h0, 32'h00100513);
        exp_wr(64'h4, 32'h00200593);
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        pulse_start();
        chk("f_busy", 64'(busy), 64'd1);
        for (int i = 4; i < 10; i++) send_byte(img[i]);
        wait_done();
        chk("f_words", 64'(words_loaded), 64'd2);
        chk("f_err", 64'(err), 64'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the sequential processor's instruction memory. The processor core only reads that memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Issues one-cycle write strobes into the instruction memory write port.
- Holds the core in reset until the program image is fully loaded.

Parameters:
- MEM_WORDS, 256, instruction memory depth in 32-bit words; writes at index >= MEM_WORDS are suppressed.
- BASE_ADDR, 64'h0, byte address of the first instruction written.
- ADDR_W, 64, width of the write address, matching the 64-bit PC.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  byte address, equal to BASE_ADDR + 4*index.
- imem_wdata  output  32  assembled instruction.
- cpu_reset  output  1  reset to the processor core (pc, register_file).
- busy  output  1  a load is in progress.
- done  output  1  sticky; the last load has completed.
- err  output  1  sticky; the image exceeded MEM_WORDS.
- words_loaded  output  16  count of words actually written.

Behaviour:
- Reset values: rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_reset=1, busy=0, done=0, err=0, words_loaded=0, state=IDLE, internal counters=0.
- Stream format: 2-byte little-endian word count N, then 4*N bytes, each word little-endian (first byte goes to bits 7:0).
- A byte is accepted only on a cycle with rx_valid && rx_ready. Bytes presented when rx_ready=0 are ignored.
- States:
  - IDLE: rx_ready=0. On start, clear done, err and words_loaded, set busy=1, cpu_reset=1, go to LEN.
  - LEN: rx_ready=1. Accept 2 bytes. After the second byte: if N==0 go to FIN, else go to DATA.
  - DATA: rx_ready=1. Shift bytes into a 32-bit assembly register. On the 4th byte of a word, register the write: in the next cycle imem_we=1 for exactly 1 cycle, with imem_addr=BASE_ADDR+4*idx and imem_wdata=the assembled word. Then idx increments.
  - Write latency is 1 cycle after the 4th byte. rx_ready stays high during the write cycle, so back-to-back bytes are sustained at 1 byte/cycle.
  - When the word with idx==N-1 completes, go to FIN.
  - FIN: wait until any pending imem_we has issued, then busy=0, done=1, cpu_reset=0, go to IDLE.
- Overflow: a word with idx >= MEM_WORDS is still consumed, but no imem_we is issued and err is set to 1. words_loaded counts only issued writes.
- start while busy is ignored. start while in IDLE with done=1 reloads: cpu_reset returns to 1 in the cycle after start.
- A start pulse coincident with reset is ignored; reset wins.
- Reset mid-load aborts everything:
  - all outputs return to reset values in the next cycle;
  - a partially assembled word is discarded;
  - cpu_reset stays 1.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W; no other saturation.
- Only this block drives the instruction memory write port. The core never writes it.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, LEN, DATA, FIN);
  - the LEN_BYTES=2 and WORD_BYTES=4 constants;
  - the 64'h4 address stride constant, shared with the PC increment.
- One sub-module is natural: byte_assembler. It holds the 4-byte shift register, the byte counter, and a word_valid pulse, and is reused for the 2-byte length field with a width parameter.

Test Plan:
- Load N=2, bytes 02 00 | 13 05 10 00 | 93 05 20 00 streamed back-to-back -> imem_we at addr 0 with data 0x00100513, then at addr 4 with data 0x00200593; done=1; words_loaded=2; cpu_reset falls the cycle after the last write.
- Same image with rx_valid toggling every other cycle -> identical writes and data, only later in time; no byte lost or duplicated.
- N=0 (bytes 00 00) -> no imem_we; done=1, err=0, cpu_reset=0 within 2 cycles of the second byte.
- MEM_WORDS=2, N=3 -> writes only at addr 0 and 4; third word consumed; err=1; words_loaded=2; done=1.
- Reset asserted after 6 data bytes -> next cycle every output is at its reset value; a new start plus full image loads correctly from addr 0.
- start pulsed during DATA -> ignored, load completes normally. start after done -> done clears, cpu_reset=1, reload proceeds.
